// File: rtl/key_debounce.sv
// Push-button conditioner: per-key 2-FF synchronizer, debounce counter, and
// registered press/release/long-press pulses in the system clock domain.
module key_debounce #(
  parameter int NUM_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES   = 240000,
  parameter int LONG_PRESS_CYCLES = 24000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_pad_i,
  output logic [NUM_KEYS-1:0] key_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o,
  output logic [NUM_KEYS-1:0] long_o
);

  localparam int   DB_W      = $clog2(DEBOUNCE_CYCLES);
  localparam int   HOLD_W    = $clog2(LONG_PRESS_CYCLES);
  localparam logic REL_LVL   = ACTIVE_LOW;
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("key_debounce: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic              s1, s2;
    logic              stable;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_fired;
    logic              press_q, release_q, long_q;
    logic              p;
    logic              flip;

    // p is the synchronized level normalised so that 1 means pressed
    assign p    = s2 ^ REL_LVL;
    assign flip = (p != stable) && (db_cnt == DB_MAX);

    always_ff @(posedge clock) begin
      if (reset) begin
        s1         <= REL_LVL;
        s2         <= REL_LVL;
        stable     <= 1'b0;
        db_cnt     <= '0;
        hold_cnt   <= '0;
        long_fired <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
      end else begin
        s1        <= key_pad_i[i];
        s2        <= s1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;

        if (p == stable) begin
          db_cnt <= '0;
        end else if (flip) begin
          stable    <= p;
          db_cnt    <= '0;
          press_q   <= p;
          release_q <= ~p;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        if (!stable) begin
          hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + 1'b1;
        end

        // A release landing on the threshold cycle suppresses the long pulse
        if (flip && !p) begin
          long_fired <= 1'b0;
        end else if (stable && (hold_cnt == HOLD_MAX) && !long_fired) begin
          long_q     <= 1'b1;
          long_fired <= 1'b1;
        end
      end
    end

    assign key_o[i]     = stable;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
    assign long_o[i]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/long-press windows.
module tb_key_debounce;

  localparam int NK = 2;

  logic          clock;
  logic          reset;
  logic [NK-1:0] key_pad_i;
  logic [NK-1:0] key_o;
  logic [NK-1:0] press_o;
  logic [NK-1:0] release_o;
  logic [NK-1:0] long_o;

  int errors = 0;
  int checks = 0;

  key_debounce #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(8),
    .LONG_PRESS_CYCLES(32),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_pad_i(key_pad_i),
    .key_o(key_o),
    .press_o(press_o),
    .release_o(release_o),
    .long_o(long_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Outputs are observed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    key_pad_i = 2'b11;
    repeat (3) tick();
    checks++;
    if ({key_o, press_o, release_o, long_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000", {key_o, press_o, release_o, long_o});
    end
    reset = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      checks++;
      if ({key_o, press_o, release_o, long_o} !== 8'h00) begin
        errors++;
        $display("FAIL idle_quiet t=%0d: got %b expected 00000000", i, {key_o, press_o, release_o, long_o});
      end
    end
  endtask

  task automatic test_press_latency();
    key_pad_i[0] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (press_o[0] !== (i == 10) || key_o[0] !== (i >= 10)) begin
        errors++;
        $display("FAIL press_latency t=%0d: press=%b key=%b expected press=%b key=%b",
                 i, press_o[0], key_o[0], (i == 10), (i >= 10));
      end
    end
    key_pad_i[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (release_o[0] !== (i == 10) || key_o[0] !== (i < 10) || press_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL release_latency t=%0d: rel=%b key=%b press=%b expected rel=%b key=%b press=0",
                 i, release_o[0], key_o[0], press_o[0], (i == 10), (i < 10));
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 60; i++) begin
      key_pad_i[0] = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (key_o[0] !== 1'b0 || press_o[0] !== 1'b0 || release_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_quiet t=%0d: key=%b press=%b rel=%b expected 0 0 0",
                 i, key_o[0], press_o[0], release_o[0]);
      end
    end
    key_pad_i[0] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (press_o[0] !== (i == 10) || key_o[0] !== (i >= 10)) begin
        errors++;
        $display("FAIL bounce_settle t=%0d: press=%b key=%b expected press=%b key=%b",
                 i, press_o[0], key_o[0], (i == 10), (i >= 10));
      end
    end
    key_pad_i[0] = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_long_press();
    key_pad_i[1] = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      checks++;
      if (press_o[1] !== (i == 10) || long_o[1] !== (i == 42) || key_o[1] !== (i >= 10)) begin
        errors++;
        $display("FAIL long_press t=%0d: press=%b long=%b key=%b expected press=%b long=%b key=%b",
                 i, press_o[1], long_o[1], key_o[1], (i == 10), (i == 42), (i >= 10));
      end
    end
    key_pad_i[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (release_o[1] !== (i == 10) || key_o[1] !== (i < 10) || long_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL long_release t=%0d: rel=%b key=%b long=%b expected rel=%b key=%b long=0",
                 i, release_o[1], key_o[1], long_o[1], (i == 10), (i < 10));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NK-1:0] exp_p;
    logic [NK-1:0] exp_k;
    key_pad_i = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_p = (i == 10) ? 2'b11 : 2'b00;
      exp_k = (i >= 10) ? 2'b11 : 2'b00;
      checks++;
      if (press_o !== exp_p || key_o !== exp_k) begin
        errors++;
        $display("FAIL simultaneous_press t=%0d: press=%b key=%b expected press=%b key=%b",
                 i, press_o, key_o, exp_p, exp_k);
      end
    end
    key_pad_i = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_p = (i == 10) ? 2'b11 : 2'b00;
      checks++;
      if (release_o !== exp_p) begin
        errors++;
        $display("FAIL simultaneous_release t=%0d: rel=%b expected %b", i, release_o, exp_p);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    key_pad_i[0] = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({key_o, press_o, release_o, long_o} !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid t=%0d: got %b expected 00000000", i, {key_o, press_o, release_o, long_o});
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (press_o[0] !== (i == 10) || key_o[0] !== (i >= 10) || long_o !== 2'b00) begin
        errors++;
        $display("FAIL post_reset_press t=%0d: press=%b key=%b long=%b expected press=%b key=%b long=00",
                 i, press_o[0], key_o[0], long_o, (i == 10), (i >= 10));
      end
    end
    key_pad_i[0] = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    reset     = 1'b1;
    key_pad_i = 2'b11;
    test_reset();
    test_press_latency();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
